// File: rtl/waveform_capture.sv
// waveform_capture: arms a level-crossing trigger on the free-running ADC
// sample stream, captures an N_SAMPLES waveform with PRETRIG samples of
// history ahead of the trigger, and freezes it for the UART serializer while
// `acquire` is low for HOLDOFF cycles.
//
// Stream semantics: adc_valid qualifies adc_data in the same cycle; there is
// no backpressure, so a sample offered while the block is not storing (HOLD,
// or FILL/ARMED with enable low) is dropped. The hand-off to the serializer
// is `acquire`: while it is low, `waveform` is stable and may be read.
module waveform_capture #(
    parameter int N_SAMPLES = 64,
    parameter int PRETRIG   = 16,
    parameter int HOLDOFF   = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] adc_data,
    input  logic        adc_valid,
    input  logic        enable,
    input  logic [13:0] trig_level,
    input  logic        trig_rising,
    input  logic        force_trig,
    output logic        acquire,
    output logic [13:0] waveform [N_SAMPLES],
    output logic [15:0] trig_count,
    output logic [1:0]  state
);

    // Address, sample-counter and holdoff-counter widths.
    localparam int AW = $clog2(N_SAMPLES);
    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    // With PRETRIG == N_SAMPLES-1 the trigger sample is the last one stored.
    localparam bit NO_POST  = (N_SAMPLES - PRETRIG - 1) == 0;
    localparam int POST_END = NO_POST ? 0 : (N_SAMPLES - PRETRIG - 2);

    localparam logic [CW-1:0] FILL_LAST = CW'(PRETRIG - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_END);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [13:0]   mem [N_SAMPLES];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] start_ptr;
    logic [13:0]   prev_sample;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] post_cnt;
    logic [HW-1:0] hold_cnt;

    // Per-cycle control decoded from the current state.
    logic crossing;
    logic trig_hit;
    logic wr_en;
    logic prev_en;
    logic fill_inc;
    logic fill_clr;
    logic fill_done;
    logic trig_fire;
    logic post_inc;
    logic capture_done;
    logic hold_inc;
    logic hold_done;

    assign state = state_q;

    // A crossing compares the previous stored sample against the new one.
    assign crossing = trig_rising
                    ? ((prev_sample <  trig_level) && (adc_data >= trig_level))
                    : ((prev_sample >= trig_level) && (adc_data <  trig_level));

    // A level crossing and force_trig together still yield a single trigger.
    assign trig_hit = adc_valid && (force_trig || crossing);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (fill_done) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d = S_FILL;
                end else if (trig_fire) begin
                    state_d = capture_done ? S_HOLD : S_POST;
                end
            end
            S_POST: begin
                if (capture_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Output/control decode: which registers move this cycle.
    always_comb begin
        wr_en        = 1'b0;
        prev_en      = 1'b0;
        fill_inc     = 1'b0;
        fill_clr     = 1'b0;
        fill_done    = 1'b0;
        trig_fire    = 1'b0;
        post_inc     = 1'b0;
        capture_done = 1'b0;
        hold_inc     = 1'b0;
        hold_done    = 1'b0;
        case (state_q)
            S_FILL: begin
                prev_en = adc_valid;
                if (!enable) begin
                    fill_clr = 1'b1;
                end else if (adc_valid) begin
                    wr_en     = 1'b1;
                    fill_inc  = 1'b1;
                    fill_done = (fill_cnt == FILL_LAST);
                end
            end
            S_ARMED: begin
                prev_en = adc_valid;
                if (!enable) begin
                    fill_clr = 1'b1;
                end else if (adc_valid) begin
                    wr_en = 1'b1;
                    if (trig_hit) begin
                        trig_fire    = 1'b1;
                        capture_done = NO_POST;
                    end
                end
            end
            S_POST: begin
                prev_en = adc_valid;
                if (adc_valid) begin
                    wr_en        = 1'b1;
                    post_inc     = 1'b1;
                    capture_done = (post_cnt == POST_LAST);
                end
            end
            S_HOLD: begin
                hold_inc  = 1'b1;
                hold_done = (hold_cnt == HOLD_LAST);
            end
            default: begin
                fill_clr = 1'b1;
            end
        endcase
    end

    // Sample memory, pointers, counters and the registered acquire line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            start_ptr   <= '0;
            prev_sample <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            hold_cnt    <= '0;
            trig_count  <= '0;
            acquire     <= 1'b1;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= adc_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end

            if (prev_en) begin
                prev_sample <= adc_data;
            end

            if (fill_clr || hold_done) begin
                fill_cnt <= '0;
            end else if (fill_inc) begin
                fill_cnt <= fill_cnt + CW'(1);
            end

            // The trigger sample lands at wr_ptr, so the window opens
            // PRETRIG entries behind it.
            if (trig_fire) begin
                start_ptr <= wr_ptr - PRE_OFS;
                post_cnt  <= '0;
            end else if (post_inc) begin
                post_cnt <= post_cnt + CW'(1);
            end

            if (hold_done) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + HW'(1);
            end

            if (capture_done) begin
                trig_count <= trig_count + 16'd1;
            end

            // Low exactly for the cycles spent in HOLD.
            acquire <= (state_d != S_HOLD);
        end
    end

    // Unroll the circular memory so index 0 is the oldest captured sample.
    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            waveform[i] = mem[start_ptr + AW'(i)];
        end
    end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Upstream stage of the ADC-to-UART path.
- Takes the free-running 14-bit ADC sample stream and arms a level-crossing trigger. It then captures a 64-sample waveform with a programmable pre-trigger depth.
- Presents the waveform to the UART serializer as a stable array and drives the serializer's `acquire` line.
- `acquire` is high while arming or capturing. It drops low for a fixed holdoff window during which the serializer sends the frozen waveform.

Parameters:
- N_SAMPLES, 64, waveform length; fixed to match the serializer array.
- PRETRIG, 16, samples stored before the trigger sample; legal range 1..N_SAMPLES-1.
- HOLDOFF, 200000, clk cycles `acquire` stays low; must cover 64*30 UART bit periods.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- adc_data  in  14  ADC sample, unsigned.
- adc_valid  in  1  adc_data valid this cycle.
- enable  in  1  1 = capture allowed.
- trig_level  in  14  trigger threshold, unsigned.
- trig_rising  in  1  1 = rising crossing, 0 = falling crossing.
- force_trig  in  1  software trigger, level-sensitive, acts in ARMED only.
- acquire  out  1  1 = filling/armed/capturing; 0 = waveform frozen for readout.
- waveform  out  14 x 64  unpacked array; index 0 = oldest sample, index PRETRIG = trigger sample.
- trig_count  out  16  completed captures, wraps at 65535->0.
- state  out  2  debug: 0 FILL, 1 ARMED, 2 POST, 3 HOLD.

Behaviour:
- Reset (sync, when reset=1 at clk edge):
  - state=FILL, acquire=1, trig_count=0.
  - Write pointer wr_ptr=0, fill_cnt=0, post_cnt=0, hold_cnt=0, start_ptr=0.
  - All 64 memory entries=0, so waveform reads all 0. prev_sample=0.
- Storage: 64x14 circular memory. Write happens only on adc_valid in FILL/ARMED/POST. Each write stores mem[wr_ptr]=adc_data, then wr_ptr=wr_ptr+1 mod 64 (6-bit natural wrap).
- prev_sample loads adc_data on every valid sample in FILL/ARMED/POST.
- waveform[i] = mem[(start_ptr+i) mod 64], combinational from registers. It is stable for the whole of HOLD.
- FILL:
  - Each valid sample is written and fill_cnt++.
  - When a valid sample arrives with fill_cnt==PRETRIG-1 and enable=1, go to ARMED the next cycle.
  - enable=0: fill_cnt held at 0, no writes.
- ARMED:
  - Trigger condition, evaluated only when adc_valid=1:
    - trig_rising=1: prev_sample<trig_level and adc_data>=trig_level.
    - trig_rising=0: prev_sample>=trig_level and adc_data<trig_level.
    - Or force_trig=1.
  - On trigger, the triggering sample is written at wr_ptr. Then start_ptr = wr_ptr-PRETRIG mod 64, post_cnt=0, and the next state is POST.
  - Level crossing and force_trig in the same cycle produce one trigger.
  - enable=0: return to FILL, fill_cnt=0.
- POST:
  - Each valid sample is written and post_cnt++.
  - On the valid sample with post_cnt==N_SAMPLES-PRETRIG-2, go to HOLD next cycle. Total samples after the trigger sample is N_SAMPLES-PRETRIG-1.
  - On that same edge: trig_count++ and acquire drops to 0 (registered, visible the cycle HOLD is entered).
  - enable is ignored in POST.
  - Special case: if N_SAMPLES-PRETRIG-1==0, the trigger goes straight to HOLD.
- HOLD:
  - acquire=0, no writes, adc_valid ignored, hold_cnt++ each cycle.
  - When hold_cnt==HOLDOFF-1: acquire=1, hold_cnt=0, fill_cnt=0, go to FILL. The memory keeps old data; FILL overwrites it.
  - enable is ignored in HOLD.
- No trigger can be accepted until PRETRIG fresh samples have been stored after each HOLD.
- Latency: acquire falls exactly 1 clk after the edge that writes the last sample.
- Reset mid-operation (any state): immediate return to the reset values. If in HOLD, acquire returns to 1 on the reset edge.

Test Plan:
- Reset, then ramp adc_data 0,1,2,... every cycle with trig_level=100, trig_rising=1, PRETRIG=16 → trigger at sample 100. acquire=0 from 1 clk after sample 147 is written. waveform[0]=84, waveform[16]=100, waveform[63]=147. trig_count=1.
- Falling crossing: trig_rising=0, trig_level=50, samples 60,55,49 after ARMED → trigger on 49. waveform[16]=49, waveform[15]=55.
- force_trig=1 on a constant 10 input in ARMED → trigger. All 64 entries = 10.
- adc_valid toggling every other cycle through POST → exactly 47 valid samples after the trigger are stored. Gaps are not stored.
- HOLDOFF=20: count acquire=0 cycles = 20, then FILL. A crossing during the first 15 valid samples after HOLD is ignored; the 16th arms; the next crossing triggers.
- reset pulsed mid-POST → state=0, acquire=1, waveform all 0, trig_count unchanged at 0. Also: enable=0 in ARMED → state FILL; a later crossing is ignored until 16 new samples.
